// File: rtl/versatile_mfifo_sc_pkg.sv
// rtl/versatile_mfifo_sc_pkg.sv - shared constants, per-channel op encoding and cnt slice helper
package versatile_mfifo_sc_pkg;

  localparam int DEF_DW  = 36;
  localparam int DEF_AW  = 5;
  localparam int DEF_CHW = 3;

  // Channel operation as seen by one channel controller: {wr_en, rd_en}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_WRRD = 2'b11
  } ch_op_e;

  // LSB of channel ch's fill count inside the flattened cnt_o bus
  function automatic int cnt_lsb(input int ch, input int aw);
    return ch * (aw + 1);
  endfunction

endpackage

// File: rtl/versatile_mfifo_sc_if.sv
// rtl/versatile_mfifo_sc_if.sv - request/response bundle between the port muxes and the multi-channel FIFO
interface versatile_mfifo_sc_if #(
  parameter int DW  = 36,
  parameter int AW  = 5,
  parameter int CHW = 3
);
  localparam int NR = 1 << CHW;

  logic [DW-1:0]          wr_dat_i;
  logic                   wr_i;
  logic [CHW-1:0]         wr_sel_i;
  logic                   rd_i;
  logic [CHW-1:0]         rd_sel_i;
  logic [NR-1:0]          flush_i;
  logic [DW-1:0]          rd_dat_o;
  logic                   rd_vld_o;
  logic [CHW-1:0]         rd_ch_o;
  logic [NR-1:0]          full_o;
  logic [NR-1:0]          afull_o;
  logic [NR-1:0]          empty_o;
  logic [NR*(AW+1)-1:0]   cnt_o;
  logic                   wr_err_o;
  logic                   rd_err_o;

  modport master (
    output wr_dat_i, wr_i, wr_sel_i, rd_i, rd_sel_i, flush_i,
    input  rd_dat_o, rd_vld_o, rd_ch_o, full_o, afull_o, empty_o, cnt_o,
           wr_err_o, rd_err_o
  );

  modport slave (
    input  wr_dat_i, wr_i, wr_sel_i, rd_i, rd_sel_i, flush_i,
    output rd_dat_o, rd_vld_o, rd_ch_o, full_o, afull_o, empty_o, cnt_o,
           wr_err_o, rd_err_o
  );

endinterface

// File: rtl/mfifo_ch_ctrl.sv
// rtl/mfifo_ch_ctrl.sv - one channel's pointers, fill count and status flags
module mfifo_ch_ctrl
  import versatile_mfifo_sc_pkg::*;
#(
  parameter int AW       = 5,
  parameter int AF_LEVEL = (1 << AW) - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flush,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          afull,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF    = (AW+1)'(AF_LEVEL);

  ch_op_e op;
  assign op = ch_op_e'({wr_en, rd_en});

  // wr_en/rd_en arrive pre-qualified, so cnt can never leave 0..DEPTH
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      case (op)
        OP_WR: begin
          wptr <= wptr + AW'(1);
          cnt  <= cnt + (AW+1)'(1);
        end
        OP_RD: begin
          rptr <= rptr + AW'(1);
          cnt  <= cnt - (AW+1)'(1);
        end
        OP_WRRD: begin
          wptr <= wptr + AW'(1);
          rptr <= rptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign full  = (cnt == DEPTH);
  assign afull = (cnt >= AF);
  assign empty = (cnt == '0);

endmodule

// File: rtl/vfifo_dual_port_ram_dc_dw.sv
// rtl/vfifo_dual_port_ram_dc_dw.sv - dual-clock RAM, write on port A, registered read on port B
module vfifo_dual_port_ram_dc_dw #(
  parameter int DW = 36,
  parameter int AW = 8
) (
  input  logic          clk_a,
  input  logic          we_a,
  input  logic [AW-1:0] adr_a,
  input  logic [DW-1:0] d_a,
  input  logic          clk_b,
  input  logic          re_b,
  input  logic [AW-1:0] adr_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk_a) begin
    if (we_a) mem[adr_a] <= d_a;
  end

  always_ff @(posedge clk_b) begin
    if (re_b) q_b <= mem[adr_b];
  end

endmodule

// File: rtl/versatile_mfifo_sc.sv
// rtl/versatile_mfifo_sc.sv - multi-channel single-clock FIFO sharing one RAM, one 2**AW slice per channel
module versatile_mfifo_sc
  import versatile_mfifo_sc_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int CHW      = DEF_CHW,
  parameter int AF_LEVEL = (1 << AW) - 2
) (
  input logic                   clk,
  input logic                   rst,
  versatile_mfifo_sc_if.slave   bus
);

  localparam int NR = 1 << CHW;

  logic [AW-1:0] wptr [NR];
  logic [AW-1:0] rptr [NR];
  logic [AW:0]   cnt  [NR];
  logic [NR-1:0] full, afull, empty;
  logic [NR-1:0] wr_en, rd_en;

  logic wr_blk, rd_blk, wr_acc, rd_acc;

  // Flush wins silently; a full channel rejects even with a same-cycle read
  assign wr_blk = bus.flush_i[bus.wr_sel_i];
  assign rd_blk = bus.flush_i[bus.rd_sel_i];
  assign wr_acc = bus.wr_i && !full[bus.wr_sel_i] && !wr_blk;
  assign rd_acc = bus.rd_i && !empty[bus.rd_sel_i] && !rd_blk;

  genvar n;
  generate
    for (n = 0; n < NR; n++) begin : g_ch
      assign wr_en[n] = wr_acc && (bus.wr_sel_i == CHW'(n));
      assign rd_en[n] = rd_acc && (bus.rd_sel_i == CHW'(n));

      mfifo_ch_ctrl #(
        .AW       (AW),
        .AF_LEVEL (AF_LEVEL)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en[n]),
        .rd_en (rd_en[n]),
        .flush (bus.flush_i[n]),
        .wptr  (wptr[n]),
        .rptr  (rptr[n]),
        .cnt   (cnt[n]),
        .full  (full[n]),
        .afull (afull[n]),
        .empty (empty[n])
      );

      assign bus.cnt_o[cnt_lsb(n, AW) +: AW+1] = cnt[n];
    end
  endgenerate

  assign bus.full_o  = full;
  assign bus.afull_o = afull;
  assign bus.empty_o = empty;

  logic [CHW+AW-1:0] wr_adr, rd_adr;
  assign wr_adr = {bus.wr_sel_i, wptr[bus.wr_sel_i]};
  assign rd_adr = {bus.rd_sel_i, rptr[bus.rd_sel_i]};

  // The RAM's registered read port is the read pipeline stage for rd_dat_o
  vfifo_dual_port_ram_dc_dw #(
    .DW (DW),
    .AW (CHW + AW)
  ) u_ram (
    .clk_a (clk),
    .we_a  (wr_acc),
    .adr_a (wr_adr),
    .d_a   (bus.wr_dat_i),
    .clk_b (clk),
    .re_b  (rd_acc),
    .adr_b (rd_adr),
    .q_b   (bus.rd_dat_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_vld_o <= 1'b0;
      bus.rd_ch_o  <= '0;
      bus.wr_err_o <= 1'b0;
      bus.rd_err_o <= 1'b0;
    end else begin
      bus.rd_vld_o <= rd_acc;
      if (rd_acc) bus.rd_ch_o <= bus.rd_sel_i;
      bus.wr_err_o <= bus.wr_i && full[bus.wr_sel_i] && !wr_blk;
      bus.rd_err_o <= bus.rd_i && empty[bus.rd_sel_i] && !rd_blk;
    end
  end

endmodule

// File: tb/tb_versatile_mfifo_sc.sv
// tb/tb_versatile_mfifo_sc.sv - table vectors, corner sequences and randomized traffic against a queue model
module tb_versatile_mfifo_sc;

  localparam int DW  = 36;
  localparam int AW  = 5;
  localparam int CHW = 3;
  localparam int NR  = 8;
  localparam int D   = 32;
  localparam int AFL = 30;
  localparam int CW  = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  versatile_mfifo_sc_if #(.DW(DW), .AW(AW), .CHW(CHW)) bus();

  versatile_mfifo_sc #(.DW(DW), .AW(AW), .CHW(CHW), .AF_LEVEL(AFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [NR][$];
  bit            e_vld, e_werr, e_rerr;
  int            e_ch;
  logic [DW-1:0] e_dat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NR*CW-1:0] ec;
    logic [NR-1:0]    ef, ea, ee;
    for (int n = 0; n < NR; n++) begin
      ec[n*CW +: CW] = CW'(q[n].size());
      ef[n] = (q[n].size() == D);
      ea[n] = (q[n].size() >= AFL);
      ee[n] = (q[n].size() == 0);
    end
    chk("cnt_o",    64'(bus.cnt_o),   64'(ec));
    chk("full_o",   64'(bus.full_o),  64'(ef));
    chk("afull_o",  64'(bus.afull_o), 64'(ea));
    chk("empty_o",  64'(bus.empty_o), 64'(ee));
    chk("wr_err_o", 64'(bus.wr_err_o), 64'(e_werr));
    chk("rd_err_o", 64'(bus.rd_err_o), 64'(e_rerr));
    chk("rd_vld_o", 64'(bus.rd_vld_o), 64'(e_vld));
    if (e_vld) begin
      chk("rd_dat_o", 64'(bus.rd_dat_o), 64'(e_dat));
      chk("rd_ch_o",  64'(bus.rd_ch_o),  64'(e_ch));
    end
  endtask

  task automatic cycle(input bit r, input bit w, input int ws, input logic [DW-1:0] d,
                       input bit rd, input int rs, input logic [NR-1:0] fl);
    bit wacc, racc, wfull, rempty;
    rst = r;
    bus.wr_i = w;  bus.wr_sel_i = ws[CHW-1:0]; bus.wr_dat_i = d;
    bus.rd_i = rd; bus.rd_sel_i = rs[CHW-1:0]; bus.flush_i = fl;
    if (r) begin
      for (int n = 0; n < NR; n++) q[n].delete();
      e_vld = 0; e_werr = 0; e_rerr = 0;
    end else begin
      wfull  = (q[ws].size() == D);
      rempty = (q[rs].size() == 0);
      e_werr = w && wfull && !fl[ws];
      e_rerr = rd && rempty && !fl[rs];
      wacc   = w && !wfull && !fl[ws];
      racc   = rd && !rempty && !fl[rs];
      e_vld  = racc;
      if (racc) begin
        e_dat = q[rs].pop_front();
        e_ch  = rs;
      end
      if (wacc) q[ws].push_back(d);
      for (int n = 0; n < NR; n++) if (fl[n]) q[n].delete();
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0, '0);
  endtask

  typedef struct {
    bit            r;
    bit            w;
    int            ws;
    logic [DW-1:0] d;
    bit            rd;
    int            rs;
    logic [NR-1:0] fl;
    bit            x_werr;
    bit            x_rerr;
    bit            x_vld;
    logic [DW-1:0] x_dat;
    int            x_ch;
    int            x_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [63:0] rnd;
    bit          w, rd;
    int          ws, rs;
    logic [NR-1:0] fl;

    tbl[0] = '{1, 0, 0, 36'h0,   0, 0, 8'h00, 0, 0, 0, 36'h0,   0, 0};
    tbl[1] = '{0, 1, 5, 36'hA5,  1, 5, 8'h00, 0, 1, 0, 36'h0,   5, 1};
    tbl[2] = '{0, 0, 0, 36'h0,   1, 5, 8'h00, 0, 0, 1, 36'hA5,  5, 0};
    tbl[3] = '{0, 1, 3, 36'h11,  0, 0, 8'h00, 0, 0, 0, 36'h0,   3, 1};
    tbl[4] = '{0, 1, 3, 36'h22,  1, 3, 8'h08, 0, 0, 0, 36'h0,   3, 0};
    tbl[5] = '{0, 0, 0, 36'h0,   1, 3, 8'h00, 0, 1, 0, 36'h0,   3, 0};
    tbl[6] = '{0, 1, 0, 36'h7,   0, 0, 8'h01, 0, 0, 0, 36'h0,   0, 0};
    tbl[7] = '{0, 1, 0, 36'h7,   0, 0, 8'h00, 0, 0, 0, 36'h0,   0, 1};
    tbl[8] = '{0, 0, 0, 36'h0,   1, 0, 8'h80, 0, 0, 1, 36'h7,   0, 0};

    // Reset and idle
    cycle(1, 0, 0, '0, 0, 0, '0);
    cycle(1, 0, 0, '0, 0, 0, '0);
    chk("reset rd_ch_o", 64'(bus.rd_ch_o), 64'd0);
    idle();
    chk("idle empty_o", 64'(bus.empty_o), 64'hFF);

    // Ch2 fill to full, overflow, drain in order
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, 2, DW'(i), 0, 0, '0);
      chk("ch2 afull during fill", 64'(bus.afull_o[2]), 64'(i + 1 >= AFL));
    end
    chk("ch2 full", 64'(bus.full_o[2]), 64'd1);
    cycle(0, 1, 2, DW'(99), 1, 2, '0);
    chk("ch2 overflow err", 64'(bus.wr_err_o), 64'd1);
    chk("ch2 cnt after wr+rd on full", 64'(bus.cnt_o[2*CW +: CW]), 64'd31);
    cycle(0, 1, 2, DW'(32), 0, 0, '0);
    for (int i = 0; i < D; i++) cycle(0, 0, 0, '0, 1, 2, '0);
    idle();

    // Interleaved ch0/ch7 writes, then drain ch7 then ch0
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, DW'(36'h100 + i), 0, 0, '0);
      cycle(0, 1, 7, DW'(36'h700 + i), 0, 0, '0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0, 1, 7, '0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0, 1, 0, '0);

    // Ch1 steady at 10 with simultaneous wr+rd across the pointer wrap
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, DW'(36'h1000 + i), 0, 0, '0);
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 1, DW'(36'h1000 + 10 + i), 1, 1, '0);
      chk("ch1 steady cnt", 64'(bus.cnt_o[1*CW +: CW]), 64'd10);
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 1, 1, '0);

    // Flush ch3 while reading it; ch4 untouched; read just before flush returns data
    for (int i = 0; i < 5; i++) cycle(0, 1, 3, DW'(36'h300 + i), 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 4, DW'(36'h400 + i), 0, 0, '0);
    cycle(0, 0, 0, '0, 1, 3, '0);
    chk("read before flush vld", 64'(bus.rd_vld_o), 64'd1);
    cycle(0, 0, 0, '0, 1, 3, 8'h08);
    chk("flush no vld", 64'(bus.rd_vld_o), 64'd0);
    chk("flush cnt3", 64'(bus.cnt_o[3*CW +: CW]), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 4, '0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 4; i++) cycle(0, 1, 6, DW'(36'h600 + i), 0, 0, '0);
    cycle(0, 0, 0, '0, 1, 6, '0);
    cycle(1, 0, 0, '0, 1, 6, '0);
    chk("rst mid-burst vld", 64'(bus.rd_vld_o), 64'd0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].r, tbl[i].w, tbl[i].ws, tbl[i].d, tbl[i].rd, tbl[i].rs, tbl[i].fl);
      chk($sformatf("tbl%0d wr_err", i), 64'(bus.wr_err_o), 64'(tbl[i].x_werr));
      chk($sformatf("tbl%0d rd_err", i), 64'(bus.rd_err_o), 64'(tbl[i].x_rerr));
      chk($sformatf("tbl%0d rd_vld", i), 64'(bus.rd_vld_o), 64'(tbl[i].x_vld));
      if (tbl[i].x_vld) chk($sformatf("tbl%0d rd_dat", i), 64'(bus.rd_dat_o), 64'(tbl[i].x_dat));
      chk($sformatf("tbl%0d cnt", i), 64'(bus.cnt_o[tbl[i].x_ch*CW +: CW]), 64'(tbl[i].x_cnt));
    end

    // Randomized traffic: write-heavy phase then read-heavy phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        rnd = {$urandom(), $urandom()};
        w   = (ph == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
        rd  = (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
        ws  = $urandom_range(0, 3);
        rs  = $urandom_range(0, 3);
        fl  = ($urandom_range(0, 99) == 0) ? NR'(1 << $urandom_range(0, NR - 1)) : '0;
        cycle($urandom_range(0, 499) == 0, w, ws, rnd[DW-1:0], rd, rs, fl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
